// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source feeding the input port of the 1x3 router.
//
// Takes a destination/length request and emits one router packet:
// a header byte {len, dest}, then len payload bytes streamed from an upstream
// buffer, then one parity byte (XOR of header and payload). pkt_valid is high
// for header and payload and drops together with the parity byte. The router's
// busy back-pressure holds the current byte and all state.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   start      packet request, sampled only while idle
//   dest[1:0]  destination port 0..2 (3 is illegal)
//   len[5:0]   payload byte count 1..MAX_LEN (0 is illegal)
//   pl_data    current payload byte, held by upstream until pl_ack
//   busy       router back-pressure; a byte is taken only when busy is low
//   data_out   byte presented to the router
//   pkt_valid  high during header and payload bytes
//   pl_ack     payload byte consumed at this edge
//   ready      high while idle
//   done       one-cycle pulse after the parity byte is accepted
//   err        one-cycle pulse after an illegal request
module router_pkt_tx #(
    parameter int unsigned MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       pl_ack,
    output logic       ready,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StParity
    } state_e;

    state_e     state_q;
    logic [7:0] hdr_q;
    logic [5:0] len_q;
    logic [5:0] cnt_q;
    logic [7:0] par_q;
    logic       done_q;
    logic       err_q;

    logic req_ok;
    logic last_byte;

    assign req_ok    = (dest != 2'd3) && (len != 6'd0) && ({26'd0, len} <= MAX_LEN);
    assign last_byte = (cnt_q == len_q - 6'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            hdr_q   <= 8'd0;
            len_q   <= 6'd0;
            cnt_q   <= 6'd0;
            par_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (req_ok) begin
                            hdr_q   <= {len, dest};
                            len_q   <= len;
                            cnt_q   <= 6'd0;
                            // Parity accumulation starts from the header byte.
                            par_q   <= {len, dest};
                            state_q <= StHeader;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StHeader: begin
                    if (!busy) begin
                        state_q <= StPayload;
                    end
                end
                StPayload: begin
                    if (!busy) begin
                        par_q <= par_q ^ pl_data;
                        cnt_q <= cnt_q + 6'd1;
                        if (last_byte) begin
                            state_q <= StParity;
                        end
                    end
                end
                StParity: begin
                    if (!busy) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Byte mux; payload is passed straight through so upstream sees no extra latency.
    always_comb begin
        data_out  = 8'd0;
        pkt_valid = 1'b0;
        pl_ack    = 1'b0;
        ready     = 1'b0;
        case (state_q)
            StIdle: begin
                ready = 1'b1;
            end
            StHeader: begin
                data_out  = hdr_q;
                pkt_valid = 1'b1;
            end
            StPayload: begin
                data_out  = pl_data;
                pkt_valid = 1'b1;
                pl_ack    = !busy;
            end
            StParity: begin
                data_out = par_q;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a byte-queue model of the expected packet stream is
// compared against the DUT outputs every cycle, plus literal checks per scenario.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest = 2'd0;
    logic [5:0] len = 6'd0;
    logic [7:0] pl_data;
    logic       busy = 1'b0;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       pl_ack;
    logic       ready;
    logic       done;
    logic       err;

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dest     (dest),
        .len      (len),
        .pl_data  (pl_data),
        .busy     (busy),
        .data_out (data_out),
        .pkt_valid(pkt_valid),
        .pl_ack   (pl_ack),
        .ready    (ready),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Upstream payload buffer; the model decides when a byte is consumed.
    logic [7:0] pl_mem [0:255];
    int         pl_idx = 0;
    assign pl_data = pl_mem[pl_idx];

    // Expected byte stream of the packet in flight.
    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       pl;
    } ent_t;
    ent_t q[$];

    logic exp_done = 1'b0;
    logic exp_err = 1'b0;
    bit   armed = 1'b0;
    int   cyc = 0;

    always @(posedge clk) begin : model
        logic [7:0] p;
        cyc++;
        armed = 1'b1;
        exp_done = 1'b0;
        exp_err = 1'b0;
        if (!rst) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (!busy) begin
                if (q[0].pl) pl_idx <= pl_idx + 1;
                void'(q.pop_front());
                if (q.size() == 0) exp_done = 1'b1;
            end
        end else if (start) begin
            if (dest == 2'd3 || len == 6'd0) begin
                exp_err = 1'b1;
            end else begin
                p = {len, dest};
                q.push_back('{d: p, v: 1'b1, pl: 1'b0});
                for (int i = 0; i < int'(len); i++) begin
                    p ^= pl_mem[pl_idx + i];
                    q.push_back('{d: pl_mem[pl_idx + i], v: 1'b1, pl: 1'b1});
                end
                q.push_back('{d: p, v: 1'b0, pl: 1'b0});
            end
        end
    end

    // Observation log for the literal checks.
    logic [7:0] log_d[$];
    logic       log_v[$];
    int ack_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;

    always @(negedge clk) begin : compare
        logic [7:0] ed;
        logic       ev, ea, er;
        if (armed) begin
            if (q.size() != 0) begin
                ed = q[0].d;
                ev = q[0].v;
                ea = q[0].pl && !busy;
                er = 1'b0;
            end else begin
                ed = 8'd0;
                ev = 1'b0;
                ea = 1'b0;
                er = 1'b1;
            end
            vectors++;
            if ({data_out, pkt_valid, pl_ack, ready, done, err} !==
                {ed, ev, ea, er, exp_done, exp_err}) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got data=%h vld=%b ack=%b rdy=%b done=%b err=%b, want data=%h vld=%b ack=%b rdy=%b done=%b err=%b",
                         cyc, data_out, pkt_valid, pl_ack, ready, done, err,
                         ed, ev, ea, er, exp_done, exp_err);
            end
            if (!ready) begin
                log_d.push_back(data_out);
                log_v.push_back(pkt_valid);
            end
            if (pl_ack) ack_cnt++;
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_d.delete();
        log_v.delete();
        ack_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
    endtask

    int start_cyc = 0;

    task automatic req(input logic [1:0] d, input logic [5:0] l);
        start = 1'b1;
        dest = d;
        len = l;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    int  vpat;
    bit  found;

    initial begin
        for (int i = 0; i < 256; i++) pl_mem[i] = 8'(i * 37 + 5);
        pl_mem[0] = 8'hA1;
        pl_mem[1] = 8'hA2;
        pl_mem[2] = 8'hA3;
        pl_mem[3] = 8'h5A;
        pl_mem[4] = 8'h11;
        pl_mem[5] = 8'h22;
        pl_mem[6] = 8'h33;

        // Reset
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("reset ready", int'(ready), 1);
        check("reset data_out", int'(data_out), 0);
        tick();

        // Basic packet: dest=1 len=3
        clear_log();
        req(2'd1, 6'd3);
        repeat (7) tick();
        check("basic length", log_d.size(), 5);
        if (log_d.size() == 5) begin
            check("basic header", int'(log_d[0]), 'h0D);
            check("basic pl1", int'(log_d[1]), 'hA1);
            check("basic pl3", int'(log_d[3]), 'hA3);
            check("basic parity", int'(log_d[4]), 'hAD);
            vpat = {27'd0, log_v[0], log_v[1], log_v[2], log_v[3], log_v[4]};
            check("basic pkt_valid pattern", vpat, 'b11110);
        end
        check("basic acks", ack_cnt, 3);
        check("basic done count", done_cnt, 1);
        check("basic done cycle", done_cyc - start_cyc, 5);

        // Header stall: dest=0 len=1, busy high two cycles in header
        clear_log();
        busy = 1'b1;
        req(2'd0, 6'd1);
        tick();
        tick();
        busy = 1'b0;
        repeat (4) tick();
        check("hstall length", log_d.size(), 5);
        if (log_d.size() == 5) begin
            check("hstall header0", int'(log_d[0]), 'h04);
            check("hstall header2", int'(log_d[2]), 'h04);
            check("hstall payload", int'(log_d[3]), 'h5A);
            check("hstall parity", int'(log_d[4]), 'h5E);
        end
        check("hstall acks", ack_cnt, 1);
        check("hstall done count", done_cnt, 1);

        // Payload and parity stalls, plus an illegal start mid-packet (ignored)
        clear_log();
        req(2'd2, 6'd3);
        start = 1'b1;
        dest = 2'd3;
        len = 6'd0;
        tick();
        start = 1'b0;
        tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        tick();
        check("pstall length", log_d.size(), 7);
        if (log_d.size() == 7) begin
            check("pstall held byte a", int'(log_d[2]), 'h22);
            check("pstall held byte b", int'(log_d[3]), 'h22);
            check("pstall parity", int'(log_d[6]), 'h0E);
        end
        check("pstall acks", ack_cnt, 3);
        check("pstall done count", done_cnt, 1);
        check("pstall ignored start err", err_cnt, 0);

        // Illegal requests
        clear_log();
        start = 1'b1;
        dest = 2'd3;
        len = 6'd5;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        dest = 2'd0;
        len = 6'd0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("illegal err count", err_cnt, 2);
        check("illegal no bus activity", log_d.size(), 0);

        // Max length, back-to-back
        clear_log();
        req(2'd2, 6'd63);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1'b1;
        end
        check("b2b done seen", int'(found), 1);
        if (found) begin
            #1;
            start = 1'b1;
            dest = 2'd1;
            len = 6'd2;
            tick();
            start = 1'b0;
            check("b2b acks", ack_cnt, 63);
            check("b2b first header", int'(log_d[0]), 'hFE);
            @(negedge clk);
            #1;
            check("b2b second header", int'(data_out), 'h09);
            check("b2b header after done", cyc - done_cyc, 1);
            repeat (5) tick();
            check("b2b done count", done_cnt, 2);
        end

        // Reset mid-payload
        clear_log();
        req(2'd1, 6'd4);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst data_out", int'(data_out), 0);
        check("midrst pkt_valid", int'(pkt_valid), 0);
        check("midrst ready", int'(ready), 1);
        req(2'd0, 6'd2);
        @(negedge clk);
        #1;
        check("midrst fresh header", int'(data_out), 'h08);
        repeat (5) tick();
        check("midrst done count", done_cnt, 1);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
